// File: rtl/multi_sweep_pkg.sv
// Shared types and constants for the multiplier sweep checker.
// Holds the sweep FSM state type, default parameter values and
// helpers that derive the product and error-count widths from WIDTH.
package multi_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_SETTLE   = 1;
    localparam int SETTLE_CNT_W = 4;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    function automatic int count_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/multi_sweep_if.sv
// Operand/product bus between the sweep checker and the multiplier.
// The checker is the master: it drives both operands and reads the product.
interface multi_sweep_if
    import multi_sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0]   a_out;
    logic [WIDTH-1:0]   b_out;
    logic [2*WIDTH-1:0] c_in;

    modport master (output a_out, output b_out, input c_in);
    modport slave  (input a_out, input b_out, output c_in);

endinterface

// File: rtl/multi_sweep_expgen.sv
// Operand counters and additive expected-product register.
// a is the inner loop and b the outer; the expected product follows a*b
// using only additions, so no multiplier is needed inside the checker.
module multi_sweep_expgen
    import multi_sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   expected,
    output logic                 last
);

    localparam logic [WIDTH-1:0] OP_MAX = '1;
    localparam logic [WIDTH-1:0] OP_ONE = WIDTH'(1);

    // Step to the next vector, adding b to the running product while a increments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a        <= '0;
            b        <= '0;
            expected <= '0;
        end else if (clear) begin
            a        <= '0;
            b        <= '0;
            expected <= '0;
        end else if (advance) begin
            if (a != OP_MAX) begin
                a        <= a + OP_ONE;
                expected <= expected + {{WIDTH{1'b0}}, b};
            end else begin
                a        <= '0;
                b        <= b + OP_ONE;
                expected <= '0;
            end
        end
    end

    assign last = (a == OP_MAX) && (b == OP_MAX);

endmodule

// File: rtl/multi_sweep_checker.sv
// Built-in self-test sequencer for the combinational multiplier.
// Sweeps every operand pair, holds each for SETTLE cycles, then compares
// the product against an additively generated expected value.
// Optional feature macro: MULTI_SWEEP_FIRST_ERR_EN builds the registers that
// capture the operands of the first failing vector; otherwise those ports are 0.
module multi_sweep_checker
    import multi_sweep_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    multi_sweep_if.master        mul,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int PROD_W = prod_width(WIDTH);
    localparam int CNT_W  = count_width(WIDTH);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_ONE  = SETTLE_CNT_W'(1);
    localparam logic [CNT_W-1:0]        ERR_ONE     = CNT_W'(1);

    sweep_state_t             state;
    logic [SETTLE_CNT_W-1:0]  settle_cnt;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic [PROD_W-1:0]        expected;
    logic                     last_vec;
    logic                     launch;
    logic                     mismatch;
    logic                     gen_clear;
    logic                     gen_advance;

    multi_sweep_expgen #(
        .WIDTH (WIDTH)
    ) u_expgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (gen_clear),
        .advance  (gen_advance),
        .a        (op_a),
        .b        (op_b),
        .expected (expected),
        .last     (last_vec)
    );

    assign mul.a_out = op_a;
    assign mul.b_out = op_b;

    // Decode sweep start, product mismatch and counter strobes from the current state
    always_comb begin
        launch      = 1'b0;
        mismatch    = 1'b0;
        gen_clear   = 1'b0;
        gen_advance = 1'b0;
        if ((state == IDLE) || (state == DONE)) begin
            launch = start;
        end
        if (state == CHECK) begin
            mismatch    = (mul.c_in != expected);
            gen_advance = !last_vec;
        end
        gen_clear = launch;
    end

    // Sweep FSM with settle counter, error counter and registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            err_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end
                CHECK: begin
                    settle_cnt <= '0;
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                    end
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign pass = done && (err_count == '0);

`ifdef MULTI_SWEEP_FIRST_ERR_EN
    // Remember the operands of the first failing vector of the current sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_a <= '0;
            first_err_b <= '0;
        end else if (launch) begin
            first_err_a <= '0;
            first_err_b <= '0;
        end else if (mismatch && (err_count == '0)) begin
            first_err_a <= op_a;
            first_err_b <= op_b;
        end
    end
`else
    assign first_err_a = '0;
    assign first_err_b = '0;
`endif

endmodule
